// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// Single-bit full subtractor: D = A - B - Bin, Bout is the borrow out.
module fullsubtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B with start/busy/done framing, LSB first.
// Optional signed overflow output V is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             V,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_next;

    fullsubtractor u_fs (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_borrow),
        .D    (w_d),
        .Bout (w_bo)
    );

    // Difference bits enter at the MSB so after WIDTH shifts bit 0 lands in place.
    assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            D        <= '0;
            Bout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            V        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state  <= SHIFT;
                        r_a      <= A;
                        r_b      <= B;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        D       <= w_diff_next;
                        Bout    <= w_bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // Overflow: borrow into the MSB cell differs from borrow out of it.
                        V       <= r_borrow ^ w_bo;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         V;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .D           (D),
        .Bout        (Bout),
        .busy        (busy),
        .done        (done),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .V           (V),
`endif
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench sampling in the accepting edge's following cycle (cycle 1).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
    endtask

    // cyc reports the cycle number (cycle 0 = accepting cycle) in which done is seen.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        step();
        step();
        reset = 1'b0;
        n_vec++;
        if ({busy, done, Bout} !== 3'b000 || D !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b Bout=%b D=%h, required 0 0 0 00",
                     busy, done, Bout, D);
        end
        n_vec++;
        if (dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d, required 0", dbg_state);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        n_vec++;
        if (V !== 1'b0) begin
            n_err++;
            $display("FAIL reset_v: V=%b, required 0", V);
        end
`endif
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta [4] = '{8'd100, 8'd5, 8'h80, 8'h10};
        logic [W-1:0] tb [4] = '{8'd37, 8'd9, 8'h01, 8'h05};
        logic [W-1:0] td [4] = '{8'd63, 8'hFC, 8'h7F, 8'h0B};
        logic         tbo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         tv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int cyc;
        bit busy_ok;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i]);
            n_vec++;
            if (dbg_state !== 2'd1) begin
                n_err++;
                $display("FAIL sub%0d_state: state=%0d, required 1", i, dbg_state);
            end
            wait_done(cyc, busy_ok);
            n_vec++;
            if (cyc !== 9 || !busy_ok) begin
                n_err++;
                $display("FAIL sub%0d_latency: done in cycle %0d busy_ok=%0d, required 9 1",
                         i, cyc, busy_ok);
            end
            n_vec++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL sub%0d_flags: done=%b busy=%b, required 1 0", i, done, busy);
            end
            n_vec++;
            if (D !== td[i] || Bout !== tbo[i]) begin
                n_err++;
                $display("FAIL sub%0d_result: D=%h Bout=%b, required %h %b",
                         i, D, Bout, td[i], tbo[i]);
            end
`ifdef SERIAL_SUB_OVERFLOW_EN
            n_vec++;
            if (V !== tv[i]) begin
                n_err++;
                $display("FAIL sub%0d_v: V=%b, required %b", i, V, tv[i]);
            end
`else
            if (tv[i] === 1'bx) $display("unexpected table entry");
`endif
            step();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || D !== td[i] || Bout !== tbo[i]) begin
                n_err++;
                $display("FAIL sub%0d_hold: done=%b busy=%b D=%h Bout=%b, required 0 0 %h %b",
                         i, done, busy, D, Bout, td[i], tbo[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        launch(8'd200, 8'd50);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            if (cyc == 3) begin
                start = 1'b1;
                A     = 8'd1;
                B     = 8'd1;
            end else if (cyc == 4) begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        n_vec++;
        if (cyc !== 9) begin
            n_err++;
            $display("FAIL ignore_latency: done in cycle %0d, required 9", cyc);
        end
        n_vec++;
        if (D !== 8'd150 || Bout !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: D=%0d Bout=%b, required 150 0", D, Bout);
        end
        step();
    endtask

    task automatic test_reset_midop();
        int cyc;
        bit busy_ok;
        launch(8'hF0, 8'h0F);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if ({busy, done, Bout} !== 3'b000 || D !== '0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_clear: busy=%b done=%b Bout=%b D=%h state=%0d, required 0 0 0 00 0",
                     busy, done, Bout, D, dbg_state);
        end
        step();
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: done=%b busy=%b, required 0 0", done, busy);
        end
        launch(8'd100, 8'd37);
        wait_done(cyc, busy_ok);
        n_vec++;
        if (cyc !== 9 || D !== 8'd63 || Bout !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_restart: cycle=%0d D=%0d Bout=%b, required 9 63 0",
                     cyc, D, Bout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit busy_ok;
        launch(8'h55, 8'h2A);
        start = 1'b1;
        wait_done(cyc, busy_ok);
        n_vec++;
        if (cyc !== 9 || D !== 8'h2B || Bout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: cycle=%0d D=%h Bout=%b, required 9 2b 0", cyc, D, Bout);
        end
        A = 8'h00;
        B = 8'h01;
        step();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_nogap: busy=%b done=%b, required 1 0", busy, done);
        end
        wait_done(cyc, busy_ok);
        n_vec++;
        if (cyc !== 9 || !busy_ok) begin
            n_err++;
            $display("FAIL b2b_latency: done %0d cycles after first done busy_ok=%0d, required 9 1",
                     cyc, busy_ok);
        end
        n_vec++;
        if (D !== 8'hFF || Bout !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: D=%h Bout=%b, required ff 1", D, Bout);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_subtract();
        test_start_ignored();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
